// File: rtl/mem_stage.sv
// Memory pipeline stage: E/M pipeline register, 1024x32 data memory with byte/half/word access.
// Optional macro MISALIGN_EXC_EN flags misaligned word/half accesses and suppresses flagged stores.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] IR_E,
    input  logic [31:0] pc_E,
    input  logic [31:0] pc4_E,
    input  logic [31:0] ALUout_E,
    input  logic [31:0] data2_E,
    input  logic        fwd_W,
    input  logic [31:0] mul_WD,
    output logic [31:0] IR_M,
    output logic [31:0] pc_M,
    output logic [31:0] pc4_M,
    output logic [31:0] ALUout_M,
    output logic [31:0] DMout_M,
    output logic        exc_M
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1024;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    logic [XLEN-1:0] r_ir;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc4;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_data2;
    logic [XLEN-1:0] r_mem [DEPTH];

    logic [5:0]      w_op;
    logic            w_is_lw;
    logic            w_is_lh;
    logic            w_is_lhu;
    logic            w_is_lb;
    logic            w_is_lbu;
    logic            w_is_sw;
    logic            w_is_sh;
    logic            w_is_sb;
    logic            w_is_store;
    logic            w_exc;
    logic            w_we;
    logic [AW-1:0]   w_idx;
    logic [1:0]      w_byte_sel;
    logic            w_half_sel;
    logic [XLEN-1:0] w_word;
    logic [XLEN-1:0] w_st_data;
    logic [XLEN-1:0] w_wr_word;
    logic [XLEN-1:0] w_dmout;
    logic [15:0]     w_half;
    logic [7:0]      w_byte;

    // E/M pipeline register: flush beats stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir    <= '0;
            r_pc    <= '0;
            r_pc4   <= '0;
            r_alu   <= '0;
            r_data2 <= '0;
        end else if (flush) begin
            r_ir    <= '0;
            r_pc    <= '0;
            r_pc4   <= '0;
            r_alu   <= '0;
            r_data2 <= '0;
        end else if (!stall) begin
            r_ir    <= IR_E;
            r_pc    <= pc_E;
            r_pc4   <= pc4_E;
            r_alu   <= ALUout_E;
            r_data2 <= data2_E;
        end
    end

    assign w_op       = r_ir[31:26];
    assign w_is_lw    = (w_op == OP_LW);
    assign w_is_lh    = (w_op == OP_LH);
    assign w_is_lhu   = (w_op == OP_LHU);
    assign w_is_lb    = (w_op == OP_LB);
    assign w_is_lbu   = (w_op == OP_LBU);
    assign w_is_sw    = (w_op == OP_SW);
    assign w_is_sh    = (w_op == OP_SH);
    assign w_is_sb    = (w_op == OP_SB);
    assign w_is_store = w_is_sw | w_is_sh | w_is_sb;

    // Lane selects only use the bits meaningful to the access size, so unflagged
    // misaligned word/half accesses fall back to the aligned location.
    assign w_idx      = r_alu[11:2];
    assign w_byte_sel = r_alu[1:0];
    assign w_half_sel = r_alu[1];
    assign w_word     = r_mem[w_idx];
    assign w_st_data  = fwd_W ? mul_WD : r_data2;

`ifdef MISALIGN_EXC_EN
    assign w_exc = ((w_is_lw | w_is_sw) & (r_alu[1:0] != 2'b00))
                 | ((w_is_lh | w_is_lhu | w_is_sh) & r_alu[0]);
`else
    assign w_exc = 1'b0;
`endif

    assign w_we = w_is_store & ~w_exc;

    // Load lane extraction and extension
    always_comb begin
        w_half  = w_half_sel ? w_word[31:16] : w_word[15:0];
        w_byte  = w_word[7:0];
        case (w_byte_sel)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_dmout = w_word;
        if (w_is_lh) begin
            w_dmout = {{16{w_half[15]}}, w_half};
        end else if (w_is_lhu) begin
            w_dmout = {16'h0000, w_half};
        end else if (w_is_lb) begin
            w_dmout = {{24{w_byte[7]}}, w_byte};
        end else if (w_is_lbu) begin
            w_dmout = {24'h000000, w_byte};
        end
    end

    // Read-modify-write merge of store data into the addressed word
    always_comb begin
        w_wr_word = w_word;
        if (w_is_sw) begin
            w_wr_word = w_st_data;
        end else if (w_is_sh) begin
            if (w_half_sel) begin
                w_wr_word[31:16] = w_st_data[15:0];
            end else begin
                w_wr_word[15:0] = w_st_data[15:0];
            end
        end else if (w_is_sb) begin
            case (w_byte_sel)
                2'd0:    w_wr_word[7:0]   = w_st_data[7:0];
                2'd1:    w_wr_word[15:8]  = w_st_data[7:0];
                2'd2:    w_wr_word[23:16] = w_st_data[7:0];
                default: w_wr_word[31:24] = w_st_data[7:0];
            endcase
        end
    end

    // Data memory: the store in M completes even when the stage is stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[AW'(i)] <= '0;
            end
        end else if (w_we) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

    assign IR_M     = r_ir;
    assign pc_M     = r_pc;
    assign pc4_M    = r_pc4;
    assign ALUout_M = r_alu;
    assign DMout_M  = w_dmout;
    assign exc_M    = w_exc;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a byte-addressed reference memory predicts each M-cycle output.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] IR_E, pc_E, pc4_E, ALUout_E, data2_E;
    logic        fwd_W;
    logic [31:0] mul_WD;
    logic [31:0] IR_M, pc_M, pc4_M, ALUout_M, DMout_M;
    logic        exc_M;

    mem_stage dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .flush    (flush),
        .IR_E     (IR_E),
        .pc_E     (pc_E),
        .pc4_E    (pc4_E),
        .ALUout_E (ALUout_E),
        .data2_E  (data2_E),
        .fwd_W    (fwd_W),
        .mul_WD   (mul_WD),
        .IR_M     (IR_M),
        .pc_M     (pc_M),
        .pc4_M    (pc4_M),
        .ALUout_M (ALUout_M),
        .DMout_M  (DMout_M),
        .exc_M    (exc_M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] d2;
    } minst_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] dm;
        logic        exc;
        logic [2:0]  lit_mask;   // [0] dm, [1] ir, [2] exc literal checks
        logic [31:0] lit_ir;
        logic [31:0] lit_dm;
        logic        lit_exc;
    } exp_t;

    logic [7:0] mm [4096];
    minst_t     m_cur;
    exp_t       q [$];
    int         checks = 0;
    int         errors = 0;

    localparam logic [5:0] OPS [11] = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24,
                                        6'h2B, 6'h29, 6'h28, 6'h00, 6'h0F, 6'h3F};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [11:0] a);
        logic [11:0] b;
        b = {a[11:2], 2'b00};
        return {mm[b + 12'd3], mm[b + 12'd2], mm[b + 12'd1], mm[b]};
    endfunction

    function automatic logic is_exc(input minst_t m);
`ifdef MISALIGN_EXC_EN
        logic [5:0] op;
        op = m.ir[31:26];
        if ((op == 6'h23 || op == 6'h2B) && m.alu[1:0] != 2'b00) return 1'b1;
        if ((op == 6'h21 || op == 6'h25 || op == 6'h29) && m.alu[0]) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] load_val(input minst_t m);
        logic [11:0] a;
        logic [11:0] hb;
        logic [15:0] h;
        logic [7:0]  b;
        a  = m.alu[11:0];
        hb = {a[11:1], 1'b0};
        h  = {mm[hb + 12'd1], mm[hb]};
        b  = mm[a];
        case (m.ir[31:26])
            6'h21:   return {{16{h[15]}}, h};
            6'h25:   return {16'h0000, h};
            6'h20:   return {{24{b[7]}}, b};
            6'h24:   return {24'h000000, b};
            default: return rd_word(a);
        endcase
    endfunction

    task automatic model_store(input minst_t m, input logic fwd, input logic [31:0] mul);
        logic [31:0] d;
        logic [11:0] a;
        logic [11:0] wb;
        logic [11:0] hb;
        d  = fwd ? mul : m.d2;
        a  = m.alu[11:0];
        wb = {a[11:2], 2'b00};
        hb = {a[11:1], 1'b0};
        if (!is_exc(m)) begin
            case (m.ir[31:26])
                6'h2B: for (int k = 0; k < 4; k++) mm[wb + 12'(k)] = d[8*k +: 8];
                6'h29: begin mm[hb] = d[7:0]; mm[hb + 12'd1] = d[15:8]; end
                6'h28: mm[a] = d[7:0];
                default: ;
            endcase
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4096; i++) mm[i] = 8'h00;
        m_cur = '0;
    endtask

    function automatic logic [31:0] mk_ir(input logic [5:0] op);
        return {op, 26'($urandom)};
    endfunction

    // Drive one E-stage slot and predict what M shows after the next edge
    task automatic issue(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] d2,
                         input logic st, input logic fl, input logic fwd, input logic [31:0] mul,
                         input logic [2:0] lmask, input logic [31:0] lir, input logic [31:0] ldm,
                         input logic lexc);
        logic [31:0] pc;
        minst_t      nxt;
        exp_t        e;
        pc = $urandom & 32'hFFFF_FFFC;
        @(posedge clk);
        #2;
        IR_E = ir; pc_E = pc; pc4_E = pc + 32'd4; ALUout_E = alu; data2_E = d2;
        stall = st; flush = fl; fwd_W = fwd; mul_WD = mul;
        if (m_cur.ir[31:26] == 6'h2B || m_cur.ir[31:26] == 6'h29 || m_cur.ir[31:26] == 6'h28)
            model_store(m_cur, fwd, mul);
        nxt = '{ir: ir, pc: pc, pc4: pc + 32'd4, alu: alu, d2: d2};
        if (fl) m_cur = '0;
        else if (!st) m_cur = nxt;
        e.ir  = m_cur.ir;
        e.pc  = m_cur.pc;
        e.pc4 = m_cur.pc4;
        e.alu = m_cur.alu;
        e.dm  = load_val(m_cur);
        e.exc = is_exc(m_cur);
        e.lit_mask = lmask;
        e.lit_ir   = lir;
        e.lit_dm   = ldm;
        e.lit_exc  = lexc;
        q.push_back(e);
    endtask

    task automatic op_simple(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] d2);
        issue(mk_ir(op), alu, d2, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic op_lit_dm(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] ldm);
        issue(mk_ir(op), alu, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b001, 32'h0, ldm, 1'b0);
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            logic [5:0]  op;
            logic [31:0] alu;
            op  = OPS[$urandom_range(0, 10)];
            alu = {20'($urandom), 12'($urandom_range(0, 255))};
            issue(mk_ir(op), alu, $urandom, ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 30), $urandom,
                  3'b000, 32'h0, 32'h0, 1'b0);
        end
    endtask

    // Monitor: every M cycle is an observable output slot
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("IR_M", IR_M, e.ir);
                chk("pc_M", pc_M, e.pc);
                chk("pc4_M", pc4_M, e.pc4);
                chk("ALUout_M", ALUout_M, e.alu);
                chk("DMout_M", DMout_M, e.dm);
                chk("exc_M", {31'h0, exc_M}, {31'h0, e.exc});
                if (e.lit_mask[0]) chk("DMout_M_lit", DMout_M, e.lit_dm);
                if (e.lit_mask[1]) chk("IR_M_lit", IR_M, e.lit_ir);
                if (e.lit_mask[2]) chk("exc_M_lit", {31'h0, exc_M}, {31'h0, e.lit_exc});
            end
        end
    end

    initial begin
        logic [31:0] ir_a;
        logic [31:0] st_addr;
        reset = 1'b0; stall = 1'b0; flush = 1'b1; fwd_W = 1'b0; mul_WD = '0;
        IR_E = '0; pc_E = '0; pc4_E = '0; ALUout_E = '0; data2_E = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #4 reset = 1'b1;
        #1;
        chk("post_reset_IR", IR_M, 32'h0);
        chk("post_reset_DM", DMout_M, 32'h0);
        chk("post_reset_exc", {31'h0, exc_M}, 32'h0);

        op_lit_dm(6'h23, 32'h0000_0123, 32'h0000_0000);

        // Byte lanes
        op_simple(6'h2B, 32'h0000_0010, 32'h1122_3344);
        op_simple(6'h28, 32'h0000_0013, 32'h0000_00AA);
        op_lit_dm(6'h23, 32'h0000_0010, 32'hAA22_3344);
        op_lit_dm(6'h20, 32'h0000_0013, 32'hFFFF_FFAA);
        op_lit_dm(6'h24, 32'h0000_0013, 32'h0000_00AA);

        // Halfword
        op_simple(6'h29, 32'h0000_0022, 32'h0000_8001);
        op_lit_dm(6'h21, 32'h0000_0022, 32'hFFFF_8001);
        op_lit_dm(6'h25, 32'h0000_0022, 32'h0000_8001);
        op_lit_dm(6'h23, 32'h0000_0020, 32'h8001_0000);

        // Forwarding: fwd_W/mul_WD are applied to the store while it sits in M
        op_simple(6'h2B, 32'h0000_0080, 32'h0000_0001);
        issue(mk_ir(6'h23), 32'h0000_0080, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF,
              3'b001, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Misaligned store
`ifdef MISALIGN_EXC_EN
        issue(mk_ir(6'h2B), 32'h0000_0041, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0,
              3'b100, 32'h0, 32'h0, 1'b1);
        issue(mk_ir(6'h23), 32'h0000_0040, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
              3'b101, 32'h0, 32'h0000_0000, 1'b0);
`else
        issue(mk_ir(6'h2B), 32'h0000_0041, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0,
              3'b100, 32'h0, 32'h0, 1'b0);
        issue(mk_ir(6'h23), 32'h0000_0040, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
              3'b101, 32'h0, 32'h1234_5678, 1'b0);
`endif

        // Stall holds M; flush wins over stall
        ir_a = mk_ir(6'h0F);
        issue(ir_a, 32'h0000_0004, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b010, ir_a, 32'h0, 1'b0);
        issue(mk_ir(6'h3F), 32'h0000_0008, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 3'b010, ir_a, 32'h0, 1'b0);
        issue(mk_ir(6'h3F), 32'h0000_0008, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 3'b010, 32'h0, 32'h0, 1'b0);

        random_phase(400);

        // Reset asserted mid-cycle while a store sits in M
        st_addr = 32'h0000_00C4;
        op_simple(6'h2B, st_addr, 32'hCAFE_F00D);
        @(posedge clk);
        #2;
        reset = 1'b0; flush = 1'b1; stall = 1'b0; IR_E = '0;
        #1;
        chk("midreset_IR", IR_M, 32'h0);
        chk("midreset_ALU", ALUout_M, 32'h0);
        chk("midreset_DM", DMout_M, 32'h0);
        repeat (2) @(posedge clk);
        #4 reset = 1'b1;
        #1;
        chk("rerelease_IR", IR_M, 32'h0);
        chk("rerelease_DM", DMout_M, 32'h0);
        chk("rerelease_exc", {31'h0, exc_M}, 32'h0);
        model_reset();
        op_lit_dm(6'h23, st_addr, 32'h0000_0000);

        random_phase(200);
        op_simple(6'h00, 32'h0, 32'h0);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clk).
REQ-003 SHALL have ports: stall  input  1  hold E/M register; flush  input  1  insert bubble into E/M register.
REQ-004 SHALL have ports: IR_E, pc_E, pc4_E, ALUout_E, data2_E  input  32 each  execute-stage instruction, PC, PC+4, ALU result/address, rt store data.
REQ-005 SHALL have ports: fwd_W  input  1  use mul_WD as store data in M; mul_WD  input  32  writeback-stage write data.
REQ-006 SHALL have ports: IR_M, pc_M, pc4_M, ALUout_M  output  32 each  registered copies of the E-stage inputs.
REQ-007 SHALL have ports: DMout_M  output  32  extended load data; exc_M  output  1  misaligned-access flag.

Function
REQ-008 On a rising clk edge with flush=1, SHALL load IR_M, pc_M, pc4_M, ALUout_M and the internal store-data register with 0; flush has priority over stall.
REQ-009 On a rising clk edge with flush=0 and stall=1, SHALL hold all E/M registers unchanged.
REQ-010 On a rising clk edge with flush=0 and stall=0, SHALL capture IR_E, pc_E, pc4_E, ALUout_E and data2_E into the E/M registers.
REQ-011 SHALL decode IR_M[31:26]: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24, sw 0x2B, sh 0x29, sb 0x28; all other opcodes are non-memory.
REQ-012 SHALL hold a 1024 x 32-bit data memory, word index ALUout_M[11:2]; ALUout_M[31:12] ignored.
REQ-013 Store data SHALL be mul_WD when fwd_W=1, else the registered data2; selection is combinational in the M cycle.
REQ-014 On a rising clk edge with a store in M and exc_M=0, SHALL write: sw the full word; sh the low 16 bits to half ALUout_M[1]; sb the low 8 bits to byte ALUout_M[1:0]; other bytes unchanged (little-endian byte lanes).
REQ-015 The memory write in REQ-014 SHALL occur regardless of stall (the instruction in M completes); during a stall the same store rewrites identical data.
REQ-016 DMout_M SHALL be combinational from the addressed word, available in the same cycle: lw word; lh/lb sign-extended; lhu/lbu zero-extended; lane chosen by ALUout_M[1:0]; non-load SHALL give the raw word.
REQ-017 A load and a store at the same address in consecutive M cycles SHALL let the load read the value written at the preceding edge.
REQ-018 Latency: one cycle from E-stage inputs to IR_M/ALUout_M; zero cycles from ALUout_M to DMout_M.

Reset
REQ-019 While reset=0, SHALL force IR_M, pc_M, pc4_M, ALUout_M and store-data register to 0 and clear all memory words to 0; no write occurs.
REQ-020 After reset release, outputs SHALL read IR_M=0 (nop), DMout_M=0, exc_M=0 until the first capture edge.
REQ-021 Reset asserted mid-store SHALL take priority over the write at that edge.

Configuration
REQ-022 With macro MISALIGN_EXC_EN defined, exc_M SHALL be 1 for lw/sw with ALUout_M[1:0]!=0 or lh/lhu/sh with ALUout_M[0]=1, and a flagged store SHALL NOT modify memory.
REQ-023 Without MISALIGN_EXC_EN, exc_M SHALL be constant 0 and address bits are forced to alignment (word ops ignore [1:0], half ops ignore [0]).

Verification
REQ-024 Reset: reset=0 mid-cycle -> IR_M=0, ALUout_M=0 immediately; lw any address after release -> DMout_M=0x00000000.
REQ-025 Byte lanes: sw 0x11223344 @0x10, then sb data 0xAA @0x13 -> lw @0x10 gives 0xAA223344; lb @0x13 gives 0xFFFFFFAA; lbu @0x13 gives 0x000000AA.
REQ-026 Halfword: sh 0x8001 @0x22 -> lh @0x22 = 0xFFFF8001, lhu @0x22 = 0x00008001, lw @0x20 = 0x80010000.
REQ-027 Pipeline control: stall=1 with new IR_E -> IR_M unchanged; stall=1 and flush=1 -> IR_M=0 next edge.
REQ-028 Forwarding: sw with data2_E=0x1, fwd_W=1, mul_WD=0xDEADBEEF -> memory word = 0xDEADBEEF.
REQ-029 Misalignment with MISALIGN_EXC_EN: sw 0x12345678 @0x41 -> exc_M=1, word @0x40 unchanged; without macro -> exc_M=0, word @0x40 = 0x12345678.
